// File: rtl/mul_seq_param.sv
// Iterative WIDTH x WIDTH multiplier retiring RADIX_BITS multiplier bits per cycle,
// sign-magnitude internally, with optional low-column truncation and valid/ready handshakes.
module mul_seq_param #(
    parameter int WIDTH      = 8,
    parameter int RADIX_BITS = 2,
    parameter int TRUNC      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int N      = WIDTH / RADIX_BITS;
    localparam int P_W    = 2 * WIDTH;
    localparam int ITER_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [P_W-1:0]    KEEP_MASK = {P_W{1'b1}} << TRUNC;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

    // |v| as an unsigned WIDTH-bit value; -2^(WIDTH-1) maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        if (is_signed && sv[WIDTH-1]) begin
            return $unsigned(-sv);
        end
        return v;
    endfunction

    function automatic logic [P_W-1:0] truncate_cols(input logic [P_W-1:0] pp);
        return pp & KEEP_MASK;
    endfunction

    function automatic logic [P_W-1:0] apply_sign(input logic [P_W-1:0] mag,
                                                  input logic           neg);
        return neg ? -mag : mag;
    endfunction

    state_t              state_q,     state_d;
    logic [P_W-1:0]      acc_q,       acc_d;
    logic [ITER_W-1:0]   iter_q,      iter_d;
    logic                neg_q,       neg_d;
    logic [P_W-1:0]      out_p_q,     out_p_d;
    logic                out_valid_q, out_valid_d;

    // Operand shifters: multiplicand moves left and multiplier right by one digit
    // per iteration, so the current digit always sits in the low RADIX_BITS bits.
    logic [P_W-1:0]      mcand_q,     mcand_d;
    logic [WIDTH-1:0]    mplier_q,    mplier_d;

    logic [P_W-1:0]      pp;

    assign pp        = mcand_q * P_W'(mplier_q[RADIX_BITS-1:0]);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        iter_d      = iter_q;
        neg_d       = neg_q;
        out_p_d     = out_p_q;
        out_valid_d = out_valid_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = P_W'(magnitude(in_a, in_signed));
                    mplier_d = magnitude(in_b, in_signed);
                    neg_d    = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    acc_d    = '0;
                    iter_d   = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_q + truncate_cols(pp);
                mcand_d  = mcand_q << RADIX_BITS;
                mplier_d = mplier_q >> RADIX_BITS;
                iter_d   = iter_q + ITER_W'(1);
                if (iter_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                out_p_d     = apply_sign(acc_q, neg_q);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            iter_q      <= '0;
            neg_q       <= 1'b0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            iter_q      <= iter_d;
            neg_q       <= neg_d;
            out_p_q     <= out_p_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand shifters are reloaded on every accept, so they carry no reset.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end

endmodule

// File: tb/tb_mul_seq_param.sv
// Bench for mul_seq_param: five configurations (8-bit exact/truncated, 16-bit at radix 1/4/16)
// driven with directed corners and a randomized sweep against a reference model.
module tb_mul_seq_param;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       a_in, b_in;
    logic              s_in;
    logic [4:0]        iv, ir, ov, ordy;
    logic [1:0][15:0]  p8;
    logic [2:0][31:0]  p16;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_w8
        mul_seq_param #(.WIDTH(8), .RADIX_BITS(2), .TRUNC(g * 4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_a      (a_in[7:0]),
            .in_b      (b_in[7:0]),
            .in_signed (s_in),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_p     (p8[g])
        );
    end

    for (genvar g = 0; g < 3; g++) begin : g_w16
        mul_seq_param #(.WIDTH(16), .RADIX_BITS((g == 0) ? 1 : ((g == 1) ? 4 : 16)), .TRUNC(0)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g+2]),
            .in_ready  (ir[g+2]),
            .in_a      (a_in),
            .in_b      (b_in),
            .in_signed (s_in),
            .out_valid (ov[g+2]),
            .out_ready (ordy[g+2]),
            .out_p     (p16[g])
        );
    end

    function automatic int w_of(input int k);
        return (k < 2) ? 8 : 16;
    endfunction

    function automatic int r_of(input int k);
        case (k)
            0, 1:    return 2;
            2:       return 1;
            3:       return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int t_of(input int k);
        return (k == 1) ? 4 : 0;
    endfunction

    function automatic logic [31:0] get_p(input int k);
        if (k < 2) return {16'h0, p8[k]};
        return p16[k-2];
    endfunction

    // Exact configurations use the plain integer product; truncated ones sum
    // digit-weighted partial products of the magnitudes with low columns cleared.
    function automatic logic [31:0] model(input int k, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
        int     w, r, t;
        longint m, sa, sb, ma, mb, acc, pp, d;
        w  = w_of(k);
        r  = r_of(k);
        t  = t_of(k);
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (s && sa[w-1]) sa = sa - (longint'(1) << w);
        if (s && sb[w-1]) sb = sb - (longint'(1) << w);
        if (t == 0) begin
            acc = sa * sb;
        end else begin
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sb < 0) ? -sb : sb;
            acc = 0;
            for (int i = 0; i < w / r; i++) begin
                d   = (mb >> (i * r)) & ((longint'(1) << r) - 1);
                pp  = (ma * d) << (i * r);
                pp  = pp & ~((longint'(1) << t) - 1);
                acc = acc + pp;
            end
            if ((sa < 0) != (sb < 0)) acc = -acc;
        end
        acc = acc & ((longint'(1) << (2 * w)) - 1);
        return acc[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction on instance k: accept, measure latency, check the product,
    // hold out_ready low for 'hold' DONE cycles, then complete the handshake.
    task automatic run(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input int hold, input bit rand_rdy,
                       input logic [31:0] exp);
        int          c, n;
        logic [31:0] held;
        n    = w_of(k) / r_of(k);
        a_in = a;
        b_in = b;
        s_in = s;
        iv[k] = 1'b1;
        c = 0;
        while (!ir[k] && c < 100) begin
            step();
            c++;
        end
        chk($sformatf("k%0d ready_at_accept", k), 32'(ir[k]), 32'd1);
        step();
        iv[k] = 1'b0;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
        c = 1;
        while (!ov[k] && c < n + 20) begin
            if (rand_rdy) ordy[k] = 1'($urandom_range(0, 1));
            step();
            c++;
        end
        ordy[k] = 1'b0;
        chk($sformatf("k%0d latency", k), 32'(c), 32'(n + 2));
        chk($sformatf("k%0d product %0h*%0h s%0d", k, a, b, s), get_p(k), exp);
        held = get_p(k);
        for (int i = 0; i < hold; i++) begin
            iv[k] = i[0];
            step();
            chk($sformatf("k%0d hold_p", k), get_p(k), held);
            chk($sformatf("k%0d hold_valid", k), 32'(ov[k]), 32'd1);
            chk($sformatf("k%0d hold_in_ready", k), 32'(ir[k]), 32'd0);
        end
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
        step();
        ordy[k] = 1'b0;
        chk($sformatf("k%0d released_valid", k), 32'(ov[k]), 32'd0);
        chk($sformatf("k%0d released_ready", k), 32'(ir[k]), 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        iv    = '0;
        ordy  = '0;
        a_in  = '0;
        b_in  = '0;
        s_in  = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("k%0d reset_in_ready", k), 32'(ir[k]), 32'd1);
            chk($sformatf("k%0d reset_valid", k), 32'(ov[k]), 32'd0);
        end
        chk("reset_p8", get_p(0), 32'h0);
        chk("reset_p16", get_p(2), 32'h0);
        rst_n = 1'b1;
        step();

        run(0, 16'd255, 16'd255, 1'b0, 0, 1'b0, 32'hFE01);
        run(0, 16'd0,   16'd200, 1'b0, 0, 1'b0, 32'h0000);

        run(0, 16'h80, 16'h80, 1'b1, 0, 1'b0, 32'h4000);
        run(0, 16'hFF, 16'h01, 1'b1, 0, 1'b0, 32'hFFFF);
        run(0, 16'h7F, 16'h80, 1'b1, 0, 1'b0, 32'hC080);
        run(0, 16'h80, 16'h80, 1'b0, 0, 1'b0, 32'h4000);
        run(0, 16'hFF, 16'h01, 1'b0, 0, 1'b0, 32'h00FF);

        run(0, 16'd12, 16'd34, 1'b0, 10, 1'b0, 32'h0198);

        run(1, 16'd15, 16'd15, 1'b0, 0, 1'b0, 32'h00D0);
        run(0, 16'd15, 16'd15, 1'b0, 0, 1'b0, 32'h00E1);

        a_in  = 16'd200;
        b_in  = 16'd3;
        s_in  = 1'b0;
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midop_reset_valid", 32'(ov[0]), 32'd0);
        chk("midop_reset_ready", 32'(ir[0]), 32'd1);
        chk("midop_reset_p", get_p(0), 32'h0);
        step();
        step();
        chk("midop_reset_valid_held", 32'(ov[0]), 32'd0);
        a_in  = 16'd10;
        b_in  = 16'd10;
        iv[0] = 1'b1;
        rst_n = 1'b1;
        run(0, 16'd10, 16'd10, 1'b0, 0, 1'b0, 32'h0064);

        run(2, 16'h8000, 16'h8000, 1'b1, 0, 1'b0, 32'h4000_0000);
        run(3, 16'hFFFF, 16'h0001, 1'b1, 0, 1'b0, 32'hFFFF_FFFF);
        run(4, 16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0, 32'hFFFE_0001);

        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 30; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rs = 1'($urandom_range(0, 1));
                run(k, ra, rb, rs, $urandom_range(0, 3), 1'b1, model(k, ra, rb, rs));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/mul_seq_param.md
# mul_seq_param

Parametrised iterative multiplier that forms a WIDTH×WIDTH product over several clock cycles, retiring RADIX_BITS multiplier bits per cycle. It supports signed or unsigned operands, selected per transaction, and offers optional column truncation for approximate operation. Operands enter and results leave through valid/ready handshakes. The block is the sequential, low-area counterpart of the team's combinational 8-bit array multipliers, and slots into datapaths that already carry handshake flow control.

## Interface
- WIDTH, 8: operand width in bits; ≥2.
- RADIX_BITS, 2: multiplier (in_b) bits consumed per iteration; must divide WIDTH. N = WIDTH/RADIX_BITS iterations.
- TRUNC, 0: number of least-significant product columns discarded (0 = exact); 0 ≤ TRUNC < 2·WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  block can accept an operand transaction.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1: operands are two's complement; 0: unsigned. Sampled together with in_a and in_b.
- out_valid  out  1  out_p holds a result.
- out_ready  in  1  consumer takes the result.
- out_p  out  2·WIDTH  product.

## Operation
- States: IDLE, BUSY, FIX, DONE.
- in_ready = (state == IDLE). It is combinational from state only.
- **IDLE.** When in_valid & in_ready, the block registers:
  - magA = |in_a| and magB = |in_b|. In signed mode a negative operand is negated; in unsigned mode the raw value is taken. magnitude of −2^(WIDTH−1) is 2^(WIDTH−1) as an unsigned WIDTH-bit value.
  - neg = in_signed & (in_a[W−1] ^ in_b[W−1]).
  - acc = 0 (2·WIDTH bits) and iter = 0.
  - Then go to BUSY.
- **BUSY.** One iteration per cycle:
  - d = magB[iter·R +: R].
  - pp = (magA·d) << (iter·R), computed in 2·WIDTH bits.
  - Bits of pp below TRUNC are cleared.
  - acc += pp, modulo 2^(2W). No overflow is possible when TRUNC = 0.
  - iter increments. After iteration N−1, go to FIX.
- **FIX.**
  - out_p ← neg ? (−acc mod 2^(2W)) : acc.
  - out_valid ← 1, then go to DONE.
  - Truncation applies to the magnitude before negation, so signed results with TRUNC > 0 may have nonzero low bits.
- **DONE.**
  - out_p and out_valid are held stable.
  - On out_ready & out_valid: out_valid ← 0, go to IDLE.
  - out_p keeps its last value and is don't-care while out_valid = 0.
- With TRUNC = 0 the result is exact: the unsigned product, or the two's-complement signed product in 2·WIDTH bits.
- Only one transaction is in flight. in_valid is ignored outside IDLE, and operand inputs are don't-care outside the accept cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, so in_ready = 1.
  - out_valid = 0.
  - out_p = 0, acc = 0, iter = 0, neg = 0.
- Reset mid-operation discards the in-flight transaction; no out_valid is produced for it.
- Deassertion of reset is synchronised by the surrounding reset tree; the block itself has no synchroniser.
- Accept in cycle 0 (the handshake is sampled at the end of cycle 0):
  - BUSY occupies cycles 1..N.
  - FIX occupies cycle N+1.
  - out_valid is high from cycle N+2.
  - Latency is fixed and does not depend on the mode.
- Defaults (N = 4): out_valid is first seen in cycle 6.
- If out_ready is high in the first DONE cycle, in_ready is high in the next cycle. Minimum spacing between accepts is N+3 cycles.
- out_ready is honoured only in DONE. out_ready while out_valid = 0 has no effect.
- in_valid held high across a reset release is accepted in the first cycle after release.

## Test plan
1. **Unsigned exact.** Defaults, in_signed = 0, a = 255, b = 255 → out_p = 0xFE01, with out_valid rising exactly 6 cycles after accept. Also a = 0, b = 200 → 0x0000.
2. **Signed corners.** in_signed = 1:
   - −128 × −128 → 0x4000.
   - −1 × 1 → 0xFFFF.
   - 127 × −128 → 0xC080.
   - Same bits with in_signed = 0, 0x80 × 0x80 → 0x4000, and 0xFF × 0x01 → 0x00FF.
3. **Back-pressure.** Hold out_ready low for 10 cycles after out_valid → out_p stable, in_ready = 0, in_valid pulses ignored. Raise out_ready → one handshake, then in_ready = 1 next cycle.
4. **Truncation.** TRUNC = 4, defaults otherwise, unsigned 15 × 15 → out_p = 0x00D0. The exact result 0x00E1 is obtained with TRUNC = 0.
5. **Reset mid-operation.** Accept 200 × 3, pull rst_n low during cycle 3 → out_valid = 0 immediately, in_ready = 1. After release, 10 × 10 → out_p = 0x0064 with no stale output.
6. **Random sweep.** Run WIDTH = 16 with RADIX_BITS ∈ {1, 4, 16}, mixed modes and random out_ready stalls. Compare against a reference model for exact products and enforce the latency of N+2 cycles from accept to out_valid.
